// File: rtl/axi4_slave_ram_pkg.sv
// axi_pkg: AXI burst/response encodings and channel FSM state types shared by the RAM responder.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    // Reserved burst type or beats wider than the 32-bit bus make the whole burst an error burst.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
        return !(burst inside {BURST_FIXED, BURST_INCR, BURST_WRAP}) || size > 3'd2;
    endfunction
endpackage

// File: rtl/axi4_slave_ram_if.sv
// axi4_slave_ram_if: AXI4 memory-mapped bus bundle (AW, W, B, AR, R channels).
// Modports: master drives requests and write data, slave drives ready/valid/responses.
interface axi4_slave_ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W = 1
);
    logic [ID_W-1:0] awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awlock;
    logic [3:0] awcache;
    logic [2:0] awprot;
    logic [3:0] awqos;
    logic [ID_W-1:0] awuser;
    logic awvalid;
    logic awready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic wlast;
    logic [ID_W-1:0] wuser;
    logic wvalid;
    logic wready;
    logic [ID_W-1:0] bid;
    logic [1:0] bresp;
    logic [ID_W-1:0] buser;
    logic bvalid;
    logic bready;
    logic [ID_W-1:0] arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic [1:0] arlock;
    logic [3:0] arcache;
    logic [2:0] arprot;
    logic [3:0] arqos;
    logic [ID_W-1:0] aruser;
    logic arvalid;
    logic arready;
    logic [ID_W-1:0] rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0] rresp;
    logic rlast;
    logic [ID_W-1:0] ruser;
    logic rvalid;
    logic rready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        output wdata, wstrb, wlast, wuser, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
        input awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
    );
    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
        input wdata, wstrb, wlast, wuser, wvalid, bready,
        input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
        output awready, wready, bid, bresp, buser, bvalid, arready, rid, rdata, rresp, rlast, ruser, rvalid
    );
endinterface

// File: rtl/axi4_slave_ram_mem.sv
// axi4_slave_ram_mem: word array with one byte-enabled synchronous write port and one asynchronous read port.
// Ports: clk; we/waddr/wstrb/wdata write port; raddr/rdata combinational read port. Contents are never reset.
module axi4_slave_ram_mem #(
    parameter int DATA_W = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr,
    output logic [DATA_W-1:0]            rdata
);
    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < DATA_W / 8; i++)
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    // Asynchronous read: a read beat on the same edge as a write sees the old word.
    assign rdata = mem[raddr];
endmodule

// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram: AXI4 slave RAM with independent write and read burst FSMs sharing one word array.
// Ports: clk (rising edge), rst (async active-high), s_axi (slave modport of axi4_slave_ram_if).
module axi4_slave_ram
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W = 1,
    parameter int MEM_WORDS = 1024
) (
    input logic             clk,
    input logic             rst,
    axi4_slave_ram_if.slave s_axi
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;
    logic alive;
    logic [ID_W-1:0] w_id, r_id;
    logic [ADDR_W-1:0] w_addr, r_addr;
    logic [7:0] w_len, w_cnt, r_len, r_cnt;
    logic [2:0] w_size, r_size;
    logic [1:0] w_burst, r_burst;
    logic w_err, w_bad, r_err;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [DATA_W-1:0] mem_rdata;
    logic unused_ok;

    // WRAP bursts advance like INCR; FIXED holds the address.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] burst,
                                                    input logic [2:0] size);
        return burst == BURST_FIXED ? a : a + (ADDR_W'(1) << size);
    endfunction

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs = s_axi.wvalid && s_axi.wready;
    assign b_hs = s_axi.bvalid && s_axi.bready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;
    assign r_hs = s_axi.rvalid && s_axi.rready;
    assign unused_ok = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awuser, s_axi.wuser,
                         s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.aruser};

    // alive holds the address READYs low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            alive <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            alive <= 1'b1;
        end

    // Each handshake can only occur in its own state, so the handshakes alone select the transition.
    always_comb begin
        w_next = aw_hs ? W_DATA : (w_hs && w_cnt == w_len) ? W_RESP : b_hs ? W_IDLE : w_state;
        r_next = ar_hs ? R_DATA : (r_hs && r_cnt == r_len) ? R_IDLE : r_state;
    end

    always_comb begin
        s_axi.awready = alive && w_state == W_IDLE;
        s_axi.wready = w_state == W_DATA;
        s_axi.bvalid = w_state == W_RESP;
        s_axi.bid = w_id;
        s_axi.bresp = (w_err || w_bad) ? RESP_SLVERR : RESP_OKAY;
        s_axi.buser = '0;
        s_axi.arready = alive && r_state == R_IDLE;
        s_axi.rvalid = r_state == R_DATA;
        s_axi.rid = r_id;
        s_axi.rdata = (r_state == R_DATA && !r_err) ? mem_rdata : '0;
        s_axi.rresp = (r_state == R_DATA && r_err) ? RESP_SLVERR : RESP_OKAY;
        s_axi.rlast = r_state == R_DATA && r_cnt == r_len;
        s_axi.ruser = '0;
    end

    // Write burst context; w_bad latches any beat whose WLAST disagrees with the beat count.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            w_id <= '0;
            w_addr <= '0;
            w_len <= '0;
            w_size <= '0;
            w_burst <= '0;
            w_err <= 1'b0;
            w_bad <= 1'b0;
            w_cnt <= '0;
        end else if (aw_hs) begin
            w_id <= s_axi.awid;
            w_addr <= s_axi.awaddr;
            w_len <= s_axi.awlen;
            w_size <= s_axi.awsize;
            w_burst <= s_axi.awburst;
            w_err <= burst_err(s_axi.awburst, s_axi.awsize);
            w_bad <= 1'b0;
            w_cnt <= '0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_burst, w_size);
            w_cnt <= w_cnt + 8'd1;
            w_bad <= w_bad || (s_axi.wlast != (w_cnt == w_len));
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_id <= '0;
            r_addr <= '0;
            r_len <= '0;
            r_size <= '0;
            r_burst <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (ar_hs) begin
            r_id <= s_axi.arid;
            r_addr <= s_axi.araddr;
            r_len <= s_axi.arlen;
            r_size <= s_axi.arsize;
            r_burst <= s_axi.arburst;
            r_err <= burst_err(s_axi.arburst, s_axi.arsize);
            r_cnt <= '0;
        end else if (r_hs) begin
            r_addr <= next_addr(r_addr, r_burst, r_size);
            r_cnt <= r_cnt + 8'd1;
        end

    axi4_slave_ram_mem #(.DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_mem (
        .clk(clk),
        .we(w_hs && !w_err),
        .waddr(w_addr[2 +: IDX_W]),
        .wstrb(s_axi.wstrb),
        .wdata(s_axi.wdata),
        .raddr(r_addr[2 +: IDX_W]),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_axi4_slave_ram.sv
// tb_axi4_slave_ram: directed and randomized AXI4 bursts checked against an array model of the RAM.
module tb_axi4_slave_ram;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [1024];
    logic [31:0] wd [256];
    logic [3:0] ws [256];
    logic [31:0] rd [256];
    logic [1:0] rr [256];
    logic rl [256];
    logic [1:0] resp;
    logic [31:0] old;

    always #5 clk = ~clk;

    axi4_slave_ram_if #(.ADDR_W(32), .DATA_W(32), .ID_W(1)) bus ();

    axi4_slave_ram #(.ADDR_W(32), .DATA_W(32), .ID_W(1), .MEM_WORDS(1024)) dut (
        .clk(clk),
        .rst(rst),
        .s_axi(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [1:0] burst, input logic [2:0] size);
        return burst == 2'b11 || size > 3'd2;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [2:0] size, input int i);
        return burst == 2'b00 ? a : a + 32'(i) * (32'd1 << size);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [2:0] size);
        int k;
        if (!is_err(burst, size))
            for (int i = 0; i <= len; i++) begin
                k = widx(beat_addr(addr, burst, size, i));
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[k][8*b +: 8] = wd[i][8*b +: 8];
            end
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input logic [2:0] size);
        logic e;
        e = is_err(burst, size);
        for (int i = 0; i <= len; i++) begin
            check({tag, "_data"}, rd[i], e ? 32'd0 : model[widx(beat_addr(addr, burst, size, i))]);
            check({tag, "_resp"}, 32'(rr[i]), e ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
            check({tag, "_last"}, 32'(rl[i]), 32'(i == len));
        end
    endtask

    // Entered just after a falling edge; returns just after a falling edge.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [2:0] size,
                             input int last_at, input int b_delay, input logic id, output logic [1:0] r);
        int n;
        bus.awid = id;
        bus.awaddr = addr;
        bus.awlen = 8'(len);
        bus.awsize = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        if (!bus.awready) check("aw_ready_wait", 32'(bus.awready), 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata = wd[i];
            bus.wstrb = ws[i];
            bus.wlast = (i == last_at);
            n = 0;
            while (!bus.wready && n < 50) begin @(negedge clk); n++; end
            if (!bus.wready) check("w_ready_wait", 32'(bus.wready), 1);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        bus.bready = 1'b0;
        for (int k = 0; k < b_delay; k++) begin
            check("bvalid_hold", 32'(bus.bvalid), 1);
            check("awready_in_b", 32'(bus.awready), 0);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        check("bvalid", 32'(bus.bvalid), 1);
        check("bid", 32'(bus.bid), 32'(id));
        r = bus.bresp;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bvalid_drop", 32'(bus.bvalid), 0);
        check("awready_after_b", 32'(bus.awready), 1);
    endtask

    // mode 0: RREADY held high, 1: RREADY toggles 1,0,1,0..., 2: random RREADY.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [2:0] size,
                            input int mode, input logic id);
        int n, beats, cyc;
        logic stalled;
        logic [31:0] sd;
        logic [1:0] sr;
        logic sl;
        bus.arid = id;
        bus.araddr = addr;
        bus.arlen = 8'(len);
        bus.arsize = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        if (!bus.arready) check("ar_ready_wait", 32'(bus.arready), 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("rvalid_first", 32'(bus.rvalid), 1);
        check("rid", 32'(bus.rid), 32'(id));
        beats = 0;
        cyc = 0;
        stalled = 1'b0;
        sd = '0;
        sr = '0;
        sl = 1'b0;
        while (beats <= len && cyc < 2000) begin
            bus.rready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (stalled) begin
                check("r_stable_data", bus.rdata, sd);
                check("r_stable_resp", 32'(bus.rresp), 32'(sr));
                check("r_stable_last", 32'(bus.rlast), 32'(sl));
            end
            if (bus.rvalid && bus.rready) begin
                rd[beats] = bus.rdata;
                rr[beats] = bus.rresp;
                rl[beats] = bus.rlast;
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = bus.rvalid;
                sd = bus.rdata;
                sr = bus.rresp;
                sl = bus.rlast;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        if (beats <= len) check("r_beats", 32'(beats), 32'(len + 1));
        check("rvalid_end", 32'(bus.rvalid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len, last_at;
        logic [31:0] addr;
        logic [1:0] burst;
        logic [2:0] size;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awuser = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.aruser = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_bresp", 32'(bus.bresp), 0);
        check("rst_rresp", 32'(bus.rresp), 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rlast", 32'(bus.rlast), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_awready", 32'(bus.awready), 1);
        check("rel_arready", 32'(bus.arready), 1);
        @(negedge clk);

        // Fill the whole array with four 256-beat bursts, then read one back through an aliased address.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            axi_write(32'(blk * 1024), 255, BURST_INCR, 3'd2, 255, 0, 1'(blk), resp);
            model_write(32'(blk * 1024), 255, BURST_INCR, 3'd2);
            check("fill_bresp", 32'(resp), 32'(RESP_OKAY));
        end
        axi_read(32'h1000, 255, BURST_INCR, 3'd2, 0, 1'b1);
        check_read("alias", 32'h1000, 255, BURST_INCR, 3'd2);

        wd[0] = 32'h1; ws[0] = 4'hF;
        axi_write(32'h800, 0, BURST_INCR, 3'd2, 0, 0, 1'b0, resp);
        model_write(32'h800, 0, BURST_INCR, 3'd2);
        check("t1_bresp", 32'(resp), 32'(RESP_OKAY));
        axi_read(32'h800, 0, BURST_INCR, 3'd2, 0, 1'b0);
        check("t1_rdata", rd[0], 32'h1);
        check_read("t1", 32'h800, 0, BURST_INCR, 3'd2);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h100, 3, BURST_INCR, 3'd2, 3, 0, 1'b1, resp);
        model_write(32'h100, 3, BURST_INCR, 3'd2);
        check("t2_bresp", 32'(resp), 32'(RESP_OKAY));
        axi_read(32'h100, 3, BURST_INCR, 3'd2, 1, 1'b1);
        for (int i = 0; i < 4; i++) check("t2_rdata", rd[i], 32'hA0 + 32'(i));
        check_read("t2", 32'h100, 3, BURST_INCR, 3'd2);

        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        axi_write(32'h10, 0, BURST_INCR, 3'd2, 0, 0, 1'b0, resp);
        model_write(32'h10, 0, BURST_INCR, 3'd2);
        wd[0] = 32'h1234_5678; ws[0] = 4'h5;
        axi_write(32'h10, 0, BURST_INCR, 3'd2, 0, 0, 1'b0, resp);
        model_write(32'h10, 0, BURST_INCR, 3'd2);
        axi_read(32'h10, 0, BURST_INCR, 3'd2, 0, 1'b0);
        check("t3_rdata", rd[0], 32'hFF34_FF78);

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(32'h200, 3, BURST_INCR, 3'd2, 1, 0, 1'b0, resp);
        model_write(32'h200, 3, BURST_INCR, 3'd2);
        check("t4_early_wlast", 32'(resp), 32'(RESP_SLVERR));
        axi_read(32'h200, 3, BURST_INCR, 3'd2, 0, 1'b0);
        check_read("t4_early", 32'h200, 3, BURST_INCR, 3'd2);
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(32'h300, 1, 2'b11, 3'd2, 1, 0, 1'b1, resp);
        check("t4_bad_burst", 32'(resp), 32'(RESP_SLVERR));
        axi_read(32'h300, 1, BURST_INCR, 3'd2, 0, 1'b1);
        check_read("t4_unchanged", 32'h300, 1, BURST_INCR, 3'd2);

        wd[0] = 32'hCAFE_0024; ws[0] = 4'hF;
        axi_write(32'h24, 0, BURST_INCR, 3'd2, 0, 0, 1'b0, resp);
        model_write(32'h24, 0, BURST_INCR, 3'd2);
        for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h20, 2, BURST_FIXED, 3'd2, 2, 5, 1'b1, resp);
        model_write(32'h20, 2, BURST_FIXED, 3'd2);
        check("t5_bresp", 32'(resp), 32'(RESP_OKAY));
        axi_read(32'h20, 1, BURST_INCR, 3'd2, 0, 1'b0);
        check("t5_fixed_word", rd[0], 32'd3);
        check("t5_next_word", rd[1], 32'hCAFE_0024);

        // Write and read beats to one word handshake on the same edge: the read sees the old word.
        old = model[widx(32'h400)];
        wd[0] = 32'h5A5A_0400; ws[0] = 4'hF;
        fork
            axi_write(32'h400, 0, BURST_INCR, 3'd2, 0, 0, 1'b0, resp);
            axi_read(32'h400, 0, BURST_INCR, 3'd2, 0, 1'b1);
        join
        check("same_edge_old", rd[0], old);
        model_write(32'h400, 0, BURST_INCR, 3'd2);
        axi_read(32'h400, 0, BURST_INCR, 3'd2, 0, 1'b1);
        check("same_edge_new", rd[0], 32'h5A5A_0400);

        // Abort an 8-beat read with reset during its third beat.
        bus.araddr = 32'h200; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_rvalid", 32'(bus.rvalid), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_rvalid", 32'(bus.rvalid), 0);
        check("t6_rst_arready", 32'(bus.arready), 0);
        check("t6_rst_rlast", 32'(bus.rlast), 0);
        bus.rready = 1'b0;
        @(negedge clk);
        check("t6_rst_arready2", 32'(bus.arready), 0);
        check("t6_rst_awready", 32'(bus.awready), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rel_arready", 32'(bus.arready), 1);
        check("t6_rel_rvalid", 32'(bus.rvalid), 0);
        @(negedge clk);
        axi_read(32'h200, 7, BURST_INCR, 3'd2, 0, 1'b0);
        check_read("t6_after", 32'h200, 7, BURST_INCR, 3'd2);

        for (int it = 0; it < 30; it++) begin
            addr = 32'($urandom_range(0, 32'hFFFF));
            len = $urandom_range(0, 15);
            burst = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            size = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            last_at = ($urandom % 6 == 0) ? (len > 0 ? len - 1 : -1) : len;
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(addr, len, burst, size, last_at, $urandom_range(0, 2), 1'(it), resp);
            model_write(addr, len, burst, size);
            check("rand_bresp", 32'(resp),
                  (is_err(burst, size) || last_at != len) ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
            axi_read(addr, len, burst, size, 2, 1'(it));
            check_read("rand", addr, len, burst, size);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
